// File: rtl/bwt_search_ctrl.sv
// -----------------------------------------------------------------------------
// bwt_search_ctrl
//
// Controller for FM-index backward search of one short read against a BWT.
// Starting from the full suffix-array interval [0, ref_len), each base of the
// read is consumed from last to first. Each step narrows the interval:
//     lo = C[b] + Occ(b, lo)
//     hi = C[b] + Occ(b, hi)
// The search stops early as soon as the interval becomes empty.
//
// One base takes seven states:
//     FETCH -> WBASE -> REQ_LO -> WAIT_LO -> REQ_HI -> WAIT_HI -> UPDATE
// Bases come from an external read buffer with one cycle of read latency.
// Occ counts come from a shared Occ memory through a req/gnt/rvalid
// handshake. Only one Occ request is ever outstanding.
//
// Ports
//   clk          single clock; all state changes on the rising edge
//   rst          asynchronous, active-low reset
//   start        one-cycle request to search a read; accepted in IDLE only
//   read_len     number of bases in the read; sampled when start is accepted
//   ref_len      BWT length including the sentinel; stable while busy
//   c_a..c_t     C-table entries; stable while busy
//   base_addr    read-buffer address (index of the base being fetched)
//   base_data    base at base_addr, valid one cycle later (A=0 C=1 G=2 T=3)
//   occ_req      Occ lookup request
//   occ_gnt      Occ request accepted in this cycle
//   occ_addr     pointer k of Occ(b, k)
//   occ_base     base b of Occ(b, k)
//   occ_rdata    Occ result (count of b in BWT[0..k-1])
//   occ_rvalid   occ_rdata is valid
//   busy         high in every state except IDLE
//   done         one-cycle completion pulse
//   out          a match was found (final interval is not empty)
//   loc1         final interval low bound (inclusive)
//   loc2         final interval high bound (exclusive)
// -----------------------------------------------------------------------------
module bwt_search_ctrl #(
    parameter int PTR_W = 10,
    parameter int LEN_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] read_len,
    input  logic [PTR_W-1:0] ref_len,
    input  logic [PTR_W-1:0] c_a,
    input  logic [PTR_W-1:0] c_c,
    input  logic [PTR_W-1:0] c_g,
    input  logic [PTR_W-1:0] c_t,
    output logic [LEN_W-1:0] base_addr,
    input  logic [1:0]       base_data,
    output logic             occ_req,
    input  logic             occ_gnt,
    output logic [PTR_W-1:0] occ_addr,
    output logic [1:0]       occ_base,
    input  logic [PTR_W-1:0] occ_rdata,
    input  logic             occ_rvalid,
    output logic             busy,
    output logic             done,
    output logic             out,
    output logic [PTR_W-1:0] loc1,
    output logic [PTR_W-1:0] loc2
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_FETCH   = 4'd1;
    localparam logic [3:0] S_WBASE   = 4'd2;
    localparam logic [3:0] S_REQ_LO  = 4'd3;
    localparam logic [3:0] S_WAIT_LO = 4'd4;
    localparam logic [3:0] S_REQ_HI  = 4'd5;
    localparam logic [3:0] S_WAIT_HI = 4'd6;
    localparam logic [3:0] S_UPDATE  = 4'd7;
    localparam logic [3:0] S_FIN     = 4'd8;

    // ------------------------------------------------------------------
    // State registers and their next values
    // ------------------------------------------------------------------
    logic [3:0]       state_reg,  state_next;
    logic [LEN_W-1:0] idx_reg,    idx_next;     // index of the current base
    logic [1:0]       base_reg,   base_next;    // current base b
    logic [PTR_W-1:0] lo_reg,     lo_next;      // interval low
    logic [PTR_W-1:0] hi_reg,     hi_next;      // interval high
    logic [PTR_W-1:0] occ_lo_reg, occ_lo_next;  // Occ(b, lo)
    logic [PTR_W-1:0] occ_hi_reg, occ_hi_next;  // Occ(b, hi)
    logic [PTR_W-1:0] loc1_reg,   loc1_next;    // held result, low
    logic [PTR_W-1:0] loc2_reg,   loc2_next;    // held result, high
    logic             out_reg,    out_next;     // held result, match flag

    // ------------------------------------------------------------------
    // C-table lookup for the current base. This is an AND-OR mux: each
    // lane passes its entry only when it matches base_reg.
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] c_tab  [4];
    logic [PTR_W-1:0] c_term [4];
    logic [PTR_W-1:0] c_sel;

    assign c_tab[0] = c_a;
    assign c_tab[1] = c_c;
    assign c_tab[2] = c_g;
    assign c_tab[3] = c_t;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ctab
            assign c_term[gi] = (base_reg == 2'(gi)) ? c_tab[gi] : '0;
        end
    endgenerate

    assign c_sel = c_term[0] | c_term[1] | c_term[2] | c_term[3];

    // ------------------------------------------------------------------
    // Interval update arithmetic. The sums are one bit wider than the
    // pointers. A C-table plus Occ overflow therefore still compares
    // correctly for the empty-interval test, even though the stored
    // bounds are truncated.
    // ------------------------------------------------------------------
    logic [PTR_W:0] sum_lo;
    logic [PTR_W:0] sum_hi;

    assign sum_lo = {1'b0, c_sel} + {1'b0, occ_lo_reg};
    assign sum_hi = {1'b0, c_sel} + {1'b0, occ_hi_reg};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        base_next   = base_reg;
        lo_next     = lo_reg;
        hi_next     = hi_reg;
        occ_lo_next = occ_lo_reg;
        occ_hi_next = occ_hi_reg;
        loc1_next   = loc1_reg;
        loc2_next   = loc2_reg;
        out_next    = out_reg;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    lo_next = '0;
                    hi_next = ref_len;
                    if (read_len == '0) begin
                        // An empty read matches everywhere: report the
                        // full interval without touching memory.
                        state_next = S_FIN;
                    end else begin
                        idx_next   = read_len - LEN_W'(1);
                        state_next = S_FETCH;
                    end
                end
            end

            S_FETCH: begin
                // base_addr already presents idx_reg. Data arrives next cycle.
                state_next = S_WBASE;
            end

            S_WBASE: begin
                base_next  = base_data;
                state_next = S_REQ_LO;
            end

            S_REQ_LO: begin
                if (occ_gnt) begin
                    state_next = S_WAIT_LO;
                end
            end

            S_WAIT_LO: begin
                if (occ_rvalid) begin
                    occ_lo_next = occ_rdata;
                    state_next  = S_REQ_HI;
                end
            end

            S_REQ_HI: begin
                if (occ_gnt) begin
                    state_next = S_WAIT_HI;
                end
            end

            S_WAIT_HI: begin
                if (occ_rvalid) begin
                    occ_hi_next = occ_rdata;
                    state_next  = S_UPDATE;
                end
            end

            S_UPDATE: begin
                lo_next = sum_lo[PTR_W-1:0];
                hi_next = sum_hi[PTR_W-1:0];
                // Stop on an empty interval so that no further base or Occ
                // traffic is generated for a read that cannot match.
                if ((sum_lo >= sum_hi) || (idx_reg == '0)) begin
                    state_next = S_FIN;
                end else begin
                    idx_next   = idx_reg - LEN_W'(1);
                    state_next = S_FETCH;
                end
            end

            S_FIN: begin
                loc1_next  = lo_reg;
                loc2_next  = hi_reg;
                out_next   = (lo_reg < hi_reg);
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= S_IDLE;
            idx_reg    <= '0;
            base_reg   <= '0;
            lo_reg     <= '0;
            hi_reg     <= '0;
            occ_lo_reg <= '0;
            occ_hi_reg <= '0;
            loc1_reg   <= '0;
            loc2_reg   <= '0;
            out_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            base_reg   <= base_next;
            lo_reg     <= lo_next;
            hi_reg     <= hi_next;
            occ_lo_reg <= occ_lo_next;
            occ_hi_reg <= occ_hi_next;
            loc1_reg   <= loc1_next;
            loc2_reg   <= loc2_next;
            out_reg    <= out_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic in_fin;
    logic in_req_lo;
    logic in_req_hi;

    assign in_fin    = (state_reg == S_FIN);
    assign in_req_lo = (state_reg == S_REQ_LO);
    assign in_req_hi = (state_reg == S_REQ_HI);

    assign busy      = (state_reg != S_IDLE);
    assign done      = in_fin;
    assign base_addr = idx_reg;

    // The request fields come only from registers. They therefore stay
    // stable for as long as the grant is withheld.
    assign occ_req   = in_req_lo | in_req_hi;
    assign occ_addr  = in_req_hi ? hi_reg : (in_req_lo ? lo_reg : '0);
    assign occ_base  = base_reg;

    // During FIN the live interval is shown. Afterwards the captured copy
    // keeps the result visible while IDLE.
    assign loc1 = in_fin ? lo_reg            : loc1_reg;
    assign loc2 = in_fin ? hi_reg            : loc2_reg;
    assign out  = in_fin ? (lo_reg < hi_reg) : out_reg;

endmodule

// File: doc/bwt_search_ctrl.md
BWT_SEARCH_CTRL -- requirements
Module: bwt_search_ctrl

Interface
REQ-001 SHALL have parameter PTR_W, default 10, BWT pointer/interval width.
REQ-002 SHALL have parameter LEN_W, default 7, read-index width (max read 127 bases).
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1  one-cycle request to search one read; honoured in IDLE only.
REQ-006 SHALL have port read_len  in  LEN_W  bases in read; sampled on accepted start.
REQ-007 SHALL have port ref_len  in  PTR_W  BWT length including $; stable while busy.
REQ-008 SHALL have port c_a/c_c/c_g/c_t  in  PTR_W each  C-table entries; stable while busy.
REQ-009 SHALL have port base_addr  out  LEN_W  read-buffer address.
REQ-010 SHALL have port base_data  in  2  base at base_addr, valid the cycle after base_addr (A=0,C=1,G=2,T=3).
REQ-011 SHALL have port occ_req  out  1  Occ lookup request to shared Occ memory.
REQ-012 SHALL have port occ_gnt  in  1  request accepted this cycle.
REQ-013 SHALL have port occ_addr  out  PTR_W  pointer k for Occ(b,k).
REQ-014 SHALL have port occ_base  out  2  base b for Occ(b,k).
REQ-015 SHALL have port occ_rdata  in  PTR_W  Occ result; count of b in BWT[0..k-1].
REQ-016 SHALL have port occ_rvalid  in  1  occ_rdata valid; at least 1 cycle after gnt.
REQ-017 SHALL have port busy  out  1  high in every state except IDLE.
REQ-018 SHALL have port done  out  1  one-cycle completion pulse.
REQ-019 SHALL have port out  out  1  match found; held until next accepted start.
REQ-020 SHALL have port loc1  out  PTR_W  final interval low (inclusive).
REQ-021 SHALL have port loc2  out  PTR_W  final interval high (exclusive).

Function
REQ-022 SHALL perform backward search: lo=0, hi=ref_len; for i=read_len-1 down to 0, b=read[i]: lo=C[b]+Occ(b,lo), hi=C[b]+Occ(b,hi).
REQ-023 SHALL use FSM IDLE->FETCH->WBASE->REQ_LO->WAIT_LO->REQ_HI->WAIT_HI->UPDATE->(FETCH|FIN)->IDLE.
REQ-024 FETCH SHALL drive base_addr=i; WBASE SHALL latch base_data as b.
REQ-025 REQ_LO/REQ_HI SHALL hold occ_req=1 with occ_addr=lo/hi and occ_base=b stable until the cycle occ_gnt=1, then advance.
REQ-026 WAIT_LO/WAIT_HI SHALL wait for occ_rvalid and latch occ_rdata; occ_req=0 there; at most one outstanding request.
REQ-027 UPDATE SHALL compute sums at PTR_W+1 bits, write lo/hi truncated to PTR_W, and go to FIN if new lo>=hi (11-bit compare) or i==0, else decrement i and go to FETCH.
REQ-028 FIN SHALL drive loc1=lo, loc2=hi, out=(lo<hi), done=1 for exactly that cycle, then return to IDLE.
REQ-029 With zero-wait memory (gnt same cycle as req, rvalid next cycle) each base SHALL take 7 cycles; done SHALL assert 7*L+1 cycles after start for L fully matched bases.
REQ-030 read_len=0 SHALL go IDLE->FIN directly: out=1, loc1=0, loc2=ref_len, done the cycle after start.
REQ-031 start while busy SHALL be ignored with no effect on the running search.
REQ-032 Early termination on empty interval SHALL issue no further base or Occ requests.
REQ-033 loc1, loc2 and out SHALL hold their values in IDLE until the next FIN.

Reset
REQ-034 On rst=0, asynchronously: state=IDLE, busy=0, done=0, out=0, occ_req=0, loc1=0, loc2=0, base_addr=0, occ_addr=0, occ_base=0.
REQ-035 Reset mid-search SHALL abandon the search; any later occ_rvalid SHALL be ignored in IDLE.

Verification
REQ-036 BWT "T$ACG", ref_len=5, C=1/2/3/4, read "CG", zero-wait memory -> Occ queries (G,0),(G,5),(C,3),(C,4); done at cycle 15; out=1, loc1=2, loc2=3.
REQ-037 Same reference, read "GA" -> after A: lo=1,hi=2; after G: lo=3,hi=3; done after 2 bases; out=0, loc1=3, loc2=3; base_addr never 0 after index 0 fetched... exactly 2 FETCHes.
REQ-038 read_len=0 -> done 1 cycle after start, out=1, loc1=0, loc2=5, no occ_req.
REQ-039 occ_gnt withheld 3 cycles, rvalid 2 cycles after gnt -> occ_req, occ_addr, occ_base stable throughout; results identical to REQ-036.
REQ-040 rst low during WAIT_HI, late occ_rvalid pulse, then new start "CG" -> outputs zero during reset, stale rvalid ignored, REQ-036 result reproduced.
REQ-041 start pulsed while busy -> ignored; single done, original result unchanged.
